// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_ctrl
// Brief    : Sequences an external 8-bit up/down counter through load, a
//            prescaled run to a terminal value, and a one-cycle done pulse.
//            Optional macro COUNTER_SEQ_AUTO_RELOAD_EN enables DONE->LOAD reload.
// Revision : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_up,
  input  logic [7:0]       start_val,
  input  logic [7:0]       term_val,
  input  logic [DIV_W-1:0] div,
  input  logic             reload,
  input  logic [7:0]       count_y,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic             cnt_up,
  output logic             cnt_oe,
  output logic [7:0]       cnt_d,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] c_PRE_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_start_val;
  logic [7:0]       r_term_val;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pre;
  logic             r_cnt_up;
  logic             r_cnt_load;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_at_term;
  logic             w_tick;

  assign w_accept  = (r_state == S_IDLE) && start && !stop;
  assign w_at_term = (count_y == r_term_val);
  assign w_tick    = (r_pre == r_div);

  // cnt_en must react to stop and count_y within the same RUN cycle
  assign cnt_en   = (r_state == S_RUN) && !stop && !w_at_term && w_tick;
  assign cnt_load = r_cnt_load;
  assign cnt_up   = r_cnt_up;
  assign cnt_oe   = r_busy;
  assign cnt_d    = r_start_val;
  assign busy     = r_busy;
  assign done     = r_done;
  assign state    = r_state;

`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
  logic w_done_nxt;
  assign w_done_nxt = reload;
`else
  logic w_unused_reload;
  logic w_done_nxt;
  assign w_unused_reload = reload;
  assign w_done_nxt      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = stop ? S_IDLE : S_RUN;
      S_RUN: begin
        if (stop)           w_state_nxt = S_IDLE;
        else if (w_at_term) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = w_done_nxt ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_start_val <= '0;
      r_term_val  <= '0;
      r_div       <= '0;
      r_pre       <= '0;
      r_cnt_up    <= 1'b0;
      r_cnt_load  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt_load <= (w_state_nxt == S_LOAD);
      r_done     <= (w_state_nxt == S_DONE);
      r_busy     <= (w_state_nxt != S_IDLE);

      if (w_accept) begin
        r_start_val <= start_val;
        r_term_val  <= term_val;
        r_div       <= div;
        r_cnt_up    <= dir_up;
      end else if (w_state_nxt == S_IDLE) begin
        r_cnt_up <= 1'b0;
      end

      // prescaler idles at zero outside RUN so each RUN entry starts fresh
      if (r_state != S_RUN || w_tick) r_pre <= '0;
      else                            r_pre <= r_pre + c_PRE_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_seq_ctrl
// Brief    : Directed bench for counter_seq_ctrl with a behavioural counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, stop, dir_up, reload;
  logic [7:0] start_val, term_val, count_y;
  logic [3:0] div;
  logic       cnt_en, cnt_load, cnt_up, cnt_oe, busy, done;
  logic [7:0] cnt_d;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  counter_seq_ctrl #(.DIV_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir_up(dir_up),
    .start_val(start_val), .term_val(term_val), .div(div), .reload(reload),
    .count_y(count_y), .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_up(cnt_up),
    .cnt_oe(cnt_oe), .cnt_d(cnt_d), .busy(busy), .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external counter the controller drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count_y <= 8'd0;
    else if (cnt_load) count_y <= cnt_d;
    else if (cnt_en)   count_y <= cnt_up ? count_y + 8'd1 : count_y - 8'd1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // drive an accepted start for one edge; returns sitting in the LOAD cycle
  task automatic launch(input logic d, input logic [7:0] sv, input logic [7:0] tv,
                        input logic [3:0] dv);
    start = 1'b1; stop = 1'b0; dir_up = d; start_val = sv; term_val = tv; div = dv;
    tick();
    start = 1'b0;
  endtask

  // cycles = negedge index of the done pulse (0 on timeout)
  task automatic wait_done(input int first, output int cycles, output logic [31:0] mask,
                           output logic [23:0] seq);
    cycles = 0; mask = '0; seq = '0;
    for (int i = first + 1; i < first + 40; i++) begin
      tick();
      if (cnt_en) begin
        mask[i % 32] = 1'b1;
        seq = {seq[15:0], count_y};
      end
      if (done) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir_up = 1'b0; reload = 1'b0;
    start_val = 8'd0; term_val = 8'd0; div = 4'd0;
    repeat (2) tick();
    n_checks++; if (state !== 2'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if ({cnt_en, cnt_load, cnt_up, cnt_oe, busy, done} !== 6'b0) begin
      n_errors++; $display("FAIL reset_outs got=%b exp=000000", {cnt_en, cnt_load, cnt_up, cnt_oe, busy, done}); end
    n_checks++; if (cnt_d !== 8'd0) begin n_errors++; $display("FAIL reset_cnt_d got=%0d exp=0", cnt_d); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_up();
    int cyc; logic [31:0] mask; logic [23:0] seq;
    launch(1'b1, 8'd3, 8'd6, 4'd0);
    n_checks++; if (state !== 2'd1 || cnt_load !== 1'b1) begin
      n_errors++; $display("FAIL basic_load state=%0d load=%b exp=1/1", state, cnt_load); end
    n_checks++; if (cnt_d !== 8'd3) begin n_errors++; $display("FAIL basic_cnt_d got=%0d exp=3", cnt_d); end
    n_checks++; if ({busy, cnt_oe, cnt_up, cnt_en} !== 4'b1110) begin
      n_errors++; $display("FAIL basic_load_outs got=%b exp=1110", {busy, cnt_oe, cnt_up, cnt_en}); end
    wait_done(1, cyc, mask, seq);
    n_checks++; if (cyc !== 6) begin n_errors++; $display("FAIL basic_done_cycle got=%0d exp=6", cyc); end
    n_checks++; if (mask !== 32'h1C) begin n_errors++; $display("FAIL basic_en_mask got=%h exp=0000001c", mask); end
    n_checks++; if (seq !== 24'h030405) begin n_errors++; $display("FAIL basic_seq got=%h exp=030405", seq); end
    n_checks++; if (state !== 2'd3 || count_y !== 8'd6 || cnt_load !== 1'b0) begin
      n_errors++; $display("FAIL basic_done_state state=%0d y=%0d load=%b exp=3/6/0", state, count_y, cnt_load); end
    tick();
    n_checks++; if ({state, busy, cnt_oe, cnt_up, done} !== 6'b000000) begin
      n_errors++; $display("FAIL basic_idle got=%b exp=000000", {state, busy, cnt_oe, cnt_up, done}); end
    n_checks++; if (cnt_d !== 8'd3) begin n_errors++; $display("FAIL basic_idle_cnt_d got=%0d exp=3", cnt_d); end
  endtask

  task automatic test_down_prescale();
    int cyc; logic [31:0] mask; logic [23:0] seq;
    launch(1'b0, 8'd1, 8'd254, 4'd2);
    wait_done(1, cyc, mask, seq);
    n_checks++; if (cyc !== 12) begin n_errors++; $display("FAIL down_done_cycle got=%0d exp=12", cyc); end
    n_checks++; if (mask !== 32'h490) begin n_errors++; $display("FAIL down_en_mask got=%h exp=00000490", mask); end
    n_checks++; if (seq !== 24'h0100FF) begin n_errors++; $display("FAIL down_seq got=%h exp=0100ff", seq); end
    n_checks++; if (count_y !== 8'd254 || cnt_up !== 1'b0) begin
      n_errors++; $display("FAIL down_final y=%0d up=%b exp=254/0", count_y, cnt_up); end
    tick();
  endtask

  task automatic test_equal();
    int cyc; logic [31:0] mask; logic [23:0] seq;
    launch(1'b1, 8'd9, 8'd9, 4'd3);
    wait_done(1, cyc, mask, seq);
    n_checks++; if (cyc !== 3) begin n_errors++; $display("FAIL equal_done_cycle got=%0d exp=3", cyc); end
    n_checks++; if (mask !== 32'h0) begin n_errors++; $display("FAIL equal_en_mask got=%h exp=00000000", mask); end
    tick();
    n_checks++; if (state !== 2'd0 || count_y !== 8'd9) begin
      n_errors++; $display("FAIL equal_idle state=%0d y=%0d exp=0/9", state, count_y); end
  endtask

  task automatic test_stop_and_ignore();
    launch(1'b1, 8'd10, 8'd20, 4'd0);
    tick();
    start = 1'b1; start_val = 8'd77;
    tick();
    n_checks++; if (state !== 2'd2 || cnt_d !== 8'd10) begin
      n_errors++; $display("FAIL ignore_start state=%0d cnt_d=%0d exp=2/10", state, cnt_d); end
    stop = 1'b1; #1;
    n_checks++; if (cnt_en !== 1'b0) begin n_errors++; $display("FAIL stop_en got=%b exp=0", cnt_en); end
    tick();
    n_checks++; if ({state, busy, done} !== 4'b0000 || count_y !== 8'd11) begin
      n_errors++; $display("FAIL stop_idle st/busy/done=%b y=%0d exp=0000/11", {state, busy, done}, count_y); end
    tick();
    n_checks++; if (state !== 2'd0 || cnt_d !== 8'd10) begin
      n_errors++; $display("FAIL start_stop_idle state=%0d cnt_d=%0d exp=0/10", state, cnt_d); end
    start = 1'b0; stop = 1'b0; start_val = 8'd0;
  endtask

  task automatic test_reset_mid();
    launch(1'b1, 8'd40, 8'd100, 4'd1);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (state !== 2'd0) begin n_errors++; $display("FAIL mid_reset_state got=%0d exp=0", state); end
    n_checks++; if ({cnt_en, cnt_load, cnt_up, cnt_oe, busy, done, cnt_d} !== 14'b0) begin
      n_errors++; $display("FAIL mid_reset_outs got=%b exp=0", {cnt_en, cnt_load, cnt_up, cnt_oe, busy, done, cnt_d}); end
    tick();
    rst_n = 1'b1;
    launch(1'b0, 8'd5, 8'd2, 4'd0);
    n_checks++; if (state !== 2'd1 || cnt_d !== 8'd5) begin
      n_errors++; $display("FAIL first_start state=%0d cnt_d=%0d exp=1/5", state, cnt_d); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++; if (state !== 2'd0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL load_stop state=%0d busy=%b exp=0/0", state, busy); end
  endtask

  task automatic test_reload();
    int cyc; logic [31:0] mask; logic [23:0] seq;
    reload = 1'b1;
    launch(1'b1, 8'd5, 8'd7, 4'd0);
    wait_done(1, cyc, mask, seq);
    n_checks++; if (cyc !== 5) begin n_errors++; $display("FAIL reload_done_cycle got=%0d exp=5", cyc); end
    tick();
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
    n_checks++; if (state !== 2'd1 || cnt_load !== 1'b1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL reload_load state=%0d load=%b busy=%b exp=1/1/1", state, cnt_load, busy); end
    reload = 1'b0;
    wait_done(6, cyc, mask, seq);
    n_checks++; if (cyc !== 10) begin n_errors++; $display("FAIL reload_second_done got=%0d exp=10", cyc); end
    tick();
`endif
    n_checks++; if (state !== 2'd0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL reload_idle state=%0d busy=%b exp=0/0", state, busy); end
    reload = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_down_prescale();
    test_equal();
    test_stop_and_ignore();
    test_reset_mid();
    test_reload();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
